// File: rtl/gcd_pkg.sv
// Shared types and defaults for the handshaked subtractive GCD engine.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/gcd_step.sv
// One subtractive GCD iteration: either finishes with a result or shrinks the larger operand.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] next_u,
  output logic [WIDTH-1:0] next_v,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic u_zero;
  logic v_zero;

  assign u_zero = (u == '0);
  assign v_zero = (v == '0);

  always_comb begin
    next_u = u;
    next_v = v;
    done   = 1'b0;
    result = '0;
    zero   = 1'b0;
    if (u_zero && v_zero) begin
      done = 1'b1;
      zero = 1'b1;
    end else if (u_zero) begin
      done   = 1'b1;
      result = v;
    end else if (v_zero || (u == v)) begin
      done   = 1'b1;
      result = u;
    end else if (u > v) begin
      // Larger operand is always the minuend, so no wrap-around.
      next_u = u - v;
    end else begin
      next_v = v - u;
    end
  end

endmodule

// File: rtl/gcd_seq.sv
// Handshaked subtractive GCD engine, one transaction in flight.
// Optional iteration counter output enabled by GCD_SEQ_ITER_CNT_EN.
module gcd_seq
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
`ifdef GCD_SEQ_ITER_CNT_EN
  output logic [WIDTH-1:0] out_iter,
`endif
  output logic             out_zero,
  output logic             out_coprime
);

  gcd_state_t       state;
  logic [WIDTH-1:0] u;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] next_u;
  logic [WIDTH-1:0] next_v;
  logic             step_done;
  logic [WIDTH-1:0] step_result;
  logic             step_zero;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .u      (u),
    .v      (v),
    .next_u (next_u),
    .next_v (next_v),
    .done   (step_done),
    .result (step_result),
    .zero   (step_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_gcd     <= '0;
      out_zero    <= 1'b0;
      out_coprime <= 1'b0;
      u           <= '0;
      v           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            u        <= in_a;
            v        <= in_b;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (step_done) begin
            out_gcd     <= step_result;
            out_zero    <= step_zero;
            out_coprime <= (step_result == WIDTH'(1));
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            u <= next_u;
            v <= next_v;
          end
        end
        DONE: begin
          // Result fields are left untouched so they persist after the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef GCD_SEQ_ITER_CNT_EN
  // Counts CALC cycles of the current transaction; bounded by 2^WIDTH-1 so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_iter <= '0;
    end else if ((state == IDLE) && in_valid) begin
      out_iter <= '0;
    end else if (state == CALC) begin
      out_iter <= out_iter + WIDTH'(1);
    end
  end
`endif

endmodule
